// File: rtl/bp_be_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_issue_ctrl
// Brief    : Issue-side dispatch/commit controller for the BE issue queue.
//            Tracks in-flight instructions and their skip bits, serializes
//            system instructions and blanks the FE after a clear.
// Revision : 1.0 - initial release
// ============================================================================
module bp_be_issue_ctrl #(
    parameter int INFLIGHT_ELS_P       = 8,
    parameter int COMPRESSED_SUPPORT_P = 1,
    parameter int CLR_BLANK_CYCLES_P   = 2
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  issue_v_i,
    input  logic                                  issue_skip_i,
    input  logic                                  issue_serial_i,
    input  logic                                  dispatch_ready_i,
    input  logic                                  commit_v_i,
    input  logic                                  roll_i,
    input  logic                                  clr_i,
    output logic                                  dispatch_v_o,
    output logic                                  read_v_o,
    output logic                                  read_skip_o,
    output logic                                  deq_v_o,
    output logic                                  deq_skip_o,
    output logic                                  roll_v_o,
    output logic                                  clr_v_o,
    output logic                                  suppress_v_o,
    output logic [$clog2(INFLIGHT_ELS_P+1)-1:0]   inflight_cnt_o
);

    localparam int c_cnt_w = $clog2(INFLIGHT_ELS_P + 1);
    localparam int c_ptr_w = (INFLIGHT_ELS_P > 1) ? $clog2(INFLIGHT_ELS_P) : 1;
    localparam int c_blk_w = $clog2(CLR_BLANK_CYCLES_P + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(INFLIGHT_ELS_P);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_blk_w-1:0] c_blk_load = c_blk_w'(CLR_BLANK_CYCLES_P);
    localparam logic [c_blk_w-1:0] c_blk_one  = c_blk_w'(1);

    localparam logic [1:0] c_e_run    = 2'd0;
    localparam logic [1:0] c_e_serial = 2'd1;
    localparam logic [1:0] c_e_blank  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_n;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_n;
    logic [c_blk_w-1:0] r_blank_cnt;
    logic [c_blk_w-1:0] w_blank_cnt_n;
    logic [c_blk_w-1:0] w_blank_dec;
    logic               w_dispatch;
    logic               w_deq;
    logic               w_roll;
    logic               w_clr;
    logic               w_flush;
    logic               w_head_skip;
    logic               w_read_skip;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= c_e_run;
            r_blank_cnt <= '0;
        end else begin
            r_state     <= w_state_n;
            r_blank_cnt <= w_blank_cnt_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_n;
        end
    end

    // A flush squashes everything still in flight, including a same-cycle commit.
    always_comb begin
        w_cnt_n = r_cnt;
        if (w_flush) begin
            w_cnt_n = '0;
        end else begin
            w_cnt_n = r_cnt + (w_dispatch ? c_cnt_one : '0) - (w_deq ? c_cnt_one : '0);
        end
    end

    assign w_blank_dec = (r_blank_cnt != '0) ? (r_blank_cnt - c_blk_one) : '0;

    // Next-state logic
    always_comb begin
        w_state_n     = r_state;
        w_blank_cnt_n = r_blank_cnt;
        if (w_clr) begin
            w_state_n     = c_e_blank;
            w_blank_cnt_n = c_blk_load;
        end else begin
            case (r_state)
                c_e_run: begin
                    if (w_dispatch && issue_serial_i) begin
                        w_state_n = c_e_serial;
                    end
                end
                c_e_serial: begin
                    if (w_roll || (w_cnt_n == '0)) begin
                        w_state_n = c_e_run;
                    end
                end
                c_e_blank: begin
                    w_blank_cnt_n = w_blank_dec;
                    if (w_blank_dec == '0) begin
                        w_state_n = c_e_run;
                    end
                end
                default: begin
                    w_state_n = c_e_run;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        w_clr      = clr_i & ~reset_i;
        w_roll     = roll_i & ~clr_i & ~reset_i;
        w_flush    = w_clr | w_roll;
        w_dispatch = issue_v_i & dispatch_ready_i & (r_state == c_e_run)
                   & (r_cnt < c_cnt_max) & ~roll_i & ~clr_i & ~reset_i;
        w_deq      = commit_v_i & (r_cnt != '0) & ~clr_i & ~reset_i;

        dispatch_v_o   = w_dispatch;
        read_v_o       = w_dispatch;
        read_skip_o    = w_read_skip & ~reset_i;
        deq_v_o        = w_deq;
        deq_skip_o     = w_deq & w_head_skip;
        roll_v_o       = w_roll;
        clr_v_o        = w_clr;
        suppress_v_o   = (r_state == c_e_blank) & ~reset_i;
        inflight_cnt_o = reset_i ? '0 : r_cnt;
    end

    generate
        if (COMPRESSED_SUPPORT_P != 0) begin : g_skip_fifo
            localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(INFLIGHT_ELS_P - 1);
            localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

            logic [INFLIGHT_ELS_P-1:0] r_skip_mem;
            logic [c_ptr_w-1:0]        r_wr_ptr;
            logic [c_ptr_w-1:0]        r_rd_ptr;

            always_ff @(posedge clk_i) begin
                if (reset_i || w_flush) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_dispatch) begin
                        r_skip_mem[r_wr_ptr] <= issue_skip_i;
                        r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : (r_wr_ptr + c_ptr_one);
                    end
                    if (w_deq) begin
                        r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : (r_rd_ptr + c_ptr_one);
                    end
                end
            end

            assign w_head_skip = r_skip_mem[r_rd_ptr];
            assign w_read_skip = issue_skip_i;
        end else begin : g_no_skip_fifo
            assign w_head_skip = 1'b0;
            assign w_read_skip = 1'b0;
        end
    endgenerate

    // Committing with nothing in flight means upstream bookkeeping is broken.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(commit_v_i && (r_cnt == '0)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_be_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_be_issue_ctrl
// Brief    : Self-checking bench for bp_be_issue_ctrl: directed vector table,
//            corner-case sequences and randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_be_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset_i, issue_v_i, issue_skip_i, issue_serial_i;
    logic       dispatch_ready_i, commit_v_i, roll_i, clr_i;
    logic       dispatch_v_o, read_v_o, read_skip_o, deq_v_o, deq_skip_o;
    logic       roll_v_o, clr_v_o, suppress_v_o;
    logic [3:0] inflight_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_be_issue_ctrl dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .issue_v_i        (issue_v_i),
        .issue_skip_i     (issue_skip_i),
        .issue_serial_i   (issue_serial_i),
        .dispatch_ready_i (dispatch_ready_i),
        .commit_v_i       (commit_v_i),
        .roll_i           (roll_i),
        .clr_i            (clr_i),
        .dispatch_v_o     (dispatch_v_o),
        .read_v_o         (read_v_o),
        .read_skip_o      (read_skip_o),
        .deq_v_o          (deq_v_o),
        .deq_skip_o       (deq_skip_o),
        .roll_v_o         (roll_v_o),
        .clr_v_o          (clr_v_o),
        .suppress_v_o     (suppress_v_o),
        .inflight_cnt_o   (inflight_cnt_o)
    );

    typedef struct {
        bit iv, sk, rdy, cm, rl;
        bit e_disp, e_deq, e_dskip, e_roll;
        int e_cnt;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, settle, then let checks run.
    task automatic cyc(input bit iv, input bit sk, input bit ser, input bit rdy,
                       input bit cm, input bit rl, input bit cl, input bit rs);
        @(negedge clk);
        issue_v_i = iv; issue_skip_i = sk; issue_serial_i = ser; dispatch_ready_i = rdy;
        commit_v_i = cm; roll_i = rl; clr_i = cl; reset_i = rs;
        #1;
    endtask

    task automatic chk_all(input string tag, input bit e_disp, input bit e_rskip,
                           input bit e_deq, input bit e_dskip, input bit e_roll,
                           input bit e_clr, input bit e_sup, input int e_cnt);
        chk({tag, ".dispatch_v"}, int'(dispatch_v_o), int'(e_disp));
        chk({tag, ".read_v"},     int'(read_v_o),     int'(e_disp));
        chk({tag, ".read_skip"},  int'(read_skip_o),  int'(e_rskip));
        chk({tag, ".deq_v"},      int'(deq_v_o),      int'(e_deq));
        chk({tag, ".deq_skip"},   int'(deq_skip_o),   int'(e_dskip));
        chk({tag, ".roll_v"},     int'(roll_v_o),     int'(e_roll));
        chk({tag, ".clr_v"},      int'(clr_v_o),      int'(e_clr));
        chk({tag, ".suppress_v"}, int'(suppress_v_o), int'(e_sup));
        chk({tag, ".cnt"},        int'(inflight_cnt_o), e_cnt);
    endtask

    // Reference model state
    int m_cnt;
    bit m_q[$];
    bit m_serial_wait;
    int m_blank_left;

    initial begin
        bit iv, sk, ser, rdy, cm, rl, cl, rs;
        bit p_disp, p_deq, p_dskip;

        // Fill: 8 fills, blocked 9th, full-with-commit, roll with commit, refill/drain
        for (int i = 0; i < 8; i++) tbl[i] = '{1, bit'(i % 2), 1, 0, 0, 1, 0, 0, 0, i};
        tbl[8]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 8};
        tbl[9]  = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 8};
        tbl[10] = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 7};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 8};
        tbl[12] = '{0, 0, 0, 1, 1, 0, 1, 1, 1, 8};
        tbl[13] = '{1, 1, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[15] = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 1};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        cyc(1, 1, 0, 1, 0, 0, 0, 1);
        cyc(1, 1, 0, 1, 0, 0, 0, 1);
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].iv, tbl[i].sk, 0, tbl[i].rdy, tbl[i].cm, tbl[i].rl, 0, 0);
            chk_all($sformatf("tbl%0d", i), tbl[i].e_disp, tbl[i].sk, tbl[i].e_deq,
                    tbl[i].e_dskip, tbl[i].e_roll, 0, 0, tbl[i].e_cnt);
        end

        // Skip bits come back in dispatch order
        cyc(1, 1, 0, 1, 0, 0, 0, 0); chk_all("t3.d0", 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0); chk_all("t3.d1", 1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 1, 0, 0, 0, 0); chk_all("t3.d2", 1, 1, 0, 0, 0, 0, 0, 2);
        cyc(0, 0, 0, 0, 1, 0, 0, 0); chk_all("t3.c0", 0, 0, 1, 1, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 1, 0, 0, 0); chk_all("t3.c1", 0, 0, 1, 0, 0, 0, 0, 2);
        cyc(0, 0, 0, 0, 1, 0, 0, 0); chk_all("t3.c2", 0, 0, 1, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0); chk_all("t3.end", 0, 0, 0, 0, 0, 0, 0, 0);

        // Serial instruction blocks dispatch until it has drained
        cyc(1, 0, 0, 1, 0, 0, 0, 0); chk_all("t4.d0", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0); chk_all("t4.d1", 1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 1, 1, 0, 0, 0, 0); chk_all("t4.ser", 1, 0, 0, 0, 0, 0, 0, 2);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 1, 1, 0, 0, 0);
            chk_all($sformatf("t4.wait%0d", k), 0, 0, 1, 0, 0, 0, 0, 3 - k);
        end
        cyc(1, 0, 0, 1, 0, 0, 0, 0); chk_all("t4.resume", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0); chk_all("t4.drain", 0, 0, 1, 0, 0, 0, 0, 1);

        // Roll with a same-cycle commit
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0, 1, 0, 0, 0, 0);
            chk_all($sformatf("t5.d%0d", k), 1, 0, 0, 0, 0, 0, 0, k);
        end
        cyc(1, 0, 0, 1, 1, 1, 0, 0); chk_all("t5.roll", 0, 0, 1, 0, 1, 0, 0, 4);
        cyc(1, 0, 0, 1, 0, 0, 0, 0); chk_all("t5.resume", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0); chk_all("t5.drain", 0, 0, 1, 0, 0, 0, 0, 1);

        // Clear beats roll and commit, then blanks the FE; reset cuts a blank short
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 1, 0, 0, 0, 0);
            chk_all($sformatf("t6.d%0d", k), 1, 0, 0, 0, 0, 0, 0, k);
        end
        cyc(1, 0, 0, 1, 1, 1, 1, 0); chk_all("t6.clr", 0, 0, 0, 0, 0, 1, 0, 3);
        cyc(1, 0, 0, 1, 0, 0, 0, 0); chk_all("t6.blank0", 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0); chk_all("t6.blank1", 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0); chk_all("t6.resume", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0); chk_all("t6.drain", 0, 0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0); chk_all("t6.clr2", 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 1); chk_all("t6.rst", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0); chk_all("t6.post", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0); chk_all("t6.run", 1, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic against the model
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        m_cnt = 0; m_q.delete(); m_serial_wait = 0; m_blank_left = 0;
        for (int n = 0; n < 3000; n++) begin
            iv  = ($urandom_range(0, 3) != 0);
            sk  = 1'($urandom_range(0, 1));
            ser = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            cm  = (m_cnt > 0) && ($urandom_range(0, 2) != 0);
            rl  = ($urandom_range(0, 15) == 0);
            cl  = ($urandom_range(0, 19) == 0);
            rs  = ($urandom_range(0, 99) == 0);
            cyc(iv, sk, ser, rdy, cm, rl, cl, rs);

            p_disp  = iv && rdy && !m_serial_wait && (m_blank_left == 0) && (m_cnt < 8)
                      && !rl && !cl && !rs;
            p_deq   = cm && (m_cnt > 0) && !cl && !rs;
            p_dskip = p_deq ? m_q[0] : 1'b0;
            chk_all("rnd", p_disp, sk && !rs, p_deq, p_dskip, rl && !cl && !rs, cl && !rs,
                    (m_blank_left > 0) && !rs, rs ? 0 : m_cnt);

            if (rs) begin
                m_cnt = 0; m_q.delete(); m_serial_wait = 0; m_blank_left = 0;
            end else if (cl) begin
                m_cnt = 0; m_q.delete(); m_serial_wait = 0; m_blank_left = 2;
            end else begin
                if (p_deq) begin
                    void'(m_q.pop_front());
                    m_cnt--;
                end
                if (p_disp) begin
                    m_q.push_back(sk);
                    m_cnt++;
                    if (ser) m_serial_wait = 1;
                end
                if (rl) begin
                    m_cnt = 0; m_q.delete(); m_serial_wait = 0;
                end
                if (m_blank_left > 0) m_blank_left--;
                if (m_cnt == 0) m_serial_wait = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
